// File: rtl/mem_pkg.sv
// Shared size codes, FSM encodings and byte-enable helpers for the MEM-stage load/store unit.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Reserved size code 2'b11 behaves as a full word.
  function automatic logic [3:0] be_lookup(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    be_lookup = 4'b0001 << off;
      SZ_H:    be_lookup = off[1] ? 4'b1100 : 4'b0011;
      default: be_lookup = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Picks the addressed byte/half out of a raw read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[8*off_i +: 8];
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_B:    data_o = {{24{~uns_i & byte_v[7]}}, byte_v};
      SZ_H:    data_o = {{16{~uns_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake, store lane steering,
// load alignment and pipeline stall generation.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_unsignedM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        stallM,
  output logic        addr_errM,
  output logic        bus_errM
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             berr_q, berr_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic        access, misaligned;
  logic [31:0] store_data, aligned;

  assign access     = memreadM | memwriteM;
  assign misaligned = is_misaligned(mem_sizeM, AluOutM[1:0]);

  always_comb begin
    case (mem_sizeM)
      SZ_B:    store_data = {4{WriteDataM[7:0]}};
      SZ_H:    store_data = {2{WriteDataM[15:0]}};
      default: store_data = WriteDataM;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    berr_d  = berr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    case (state_q)
      ST_IDLE: begin
        // A store wins over a simultaneous load, so the write strobe simply follows memwriteM.
        if (access && !misaligned) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = memwriteM;
          addr_d  = {AluOutM[31:2], 2'b00};
          be_d    = be_lookup(mem_sizeM, AluOutM[1:0]);
          wdata_d = store_data;
          off_d   = AluOutM[1:0];
          size_d  = mem_sizeM;
          uns_d   = mem_unsignedM;
          count_d = '0;
          berr_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
          if ((TIMEOUT != 0) && (count_d == TO_VAL)) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            berr_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        count_d = '0;
        berr_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      berr_q  <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      berr_q  <= berr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  load_align u_load_align (
    .rdata_i (rdata_q),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (aligned)
  );

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign addr_errM = access & misaligned;
  assign bus_errM  = (state_q == ST_DONE) & berr_q;
  assign ReadDataM = ((state_q == ST_DONE) && !berr_q) ? aligned : 32'd0;
  // DONE drops the stall so the pipeline advances on the same edge that returns to IDLE.
  assign stallM    = (state_q == ST_IDLE) ? (access & ~misaligned) : (state_q == ST_REQ);

endmodule
